// File: rtl/psum_ofifo.sv
// psum_ofifo: one FIFO lane per MAC column, releasing column-aligned psum rows
// through a registered valid/ready output stage.
module psum_ofifo #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+6,
    parameter int depth   = 16,
    parameter int ptr_w   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*bw_psum-1:0] in,
    input  logic [col-1:0]         fifo_wr,
    output logic [col*bw_psum-1:0] out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [col-1:0]         o_ovf
);

    localparam logic [ptr_w:0] one = 1;

    logic [bw_psum-1:0] mem [col][depth];
    logic [ptr_w:0]     wr_ptr [col];
    logic [ptr_w:0]     rd_ptr [col];
    logic [col-1:0]     full;
    logic [col-1:0]     empty;
    logic [col-1:0]     wr_en;
    logic               pop;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < col; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][ptr_w] != rd_ptr[i][ptr_w]) &&
                       (wr_ptr[i][ptr_w-1:0] == rd_ptr[i][ptr_w-1:0]);
        end
    end

    // A pop frees the head slot, so a full lane may still take a write.
    assign pop     = (~|empty) & (~out_valid | out_ready);
    assign wr_en   = fifo_wr & (~full | {col{pop}});
    assign o_full  = |full;
    assign o_empty = (&empty) & ~out_valid;

    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (wr_en[i]) begin
                mem[i][wr_ptr[i][ptr_w-1:0]] <= in[i*bw_psum +: bw_psum];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < col; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            out       <= '0;
            out_valid <= 1'b0;
            o_ovf     <= '0;
        end else begin
            for (int i = 0; i < col; i++) begin
                if (wr_en[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + one;
                end
                if (pop) begin
                    rd_ptr[i] <= rd_ptr[i] + one;
                    out[i*bw_psum +: bw_psum] <= mem[i][rd_ptr[i][ptr_w-1:0]];
                end
                if (fifo_wr[i] && full[i] && !pop) begin
                    o_ovf[i] <= 1'b1;
                end
            end
            if (pop) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo: directed and random stimulus checked against a queue-based
// model of the per-column FIFOs and the output row register.
module tb_psum_ofifo;

    localparam int COL   = 8;
    localparam int BWP   = 22;
    localparam int DEPTH = 16;
    localparam int W     = COL*BWP;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   in_bus = '0;
    logic [COL-1:0] fifo_wr = '0;
    logic [W-1:0]   out;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           o_full;
    logic           o_empty;
    logic [COL-1:0] o_ovf;

    int checks = 0;
    int failures = 0;
    int accepts = 0;

    logic [BWP-1:0] q [COL][$];
    logic [W-1:0]   m_out = '0;
    logic           m_valid = 1'b0;
    logic [COL-1:0] m_ovf = '0;

    psum_ofifo dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_bus),
        .fifo_wr  (fifo_wr),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .o_full   (o_full),
        .o_empty  (o_empty),
        .o_ovf    (o_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_row();
        logic [W-1:0] r;
        logic [31:0]  v;
        r = '0;
        for (int i = 0; i < COL; i++) begin
            v = $urandom();
            r[i*BWP +: BWP] = v[BWP-1:0];
        end
        return r;
    endfunction

    function automatic logic m_full();
        logic f;
        f = 1'b0;
        for (int i = 0; i < COL; i++) if (q[i].size() == DEPTH) f = 1'b1;
        return f;
    endfunction

    function automatic logic m_empty();
        logic e;
        e = !m_valid;
        for (int i = 0; i < COL; i++) if (q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < COL; i++) q[i].delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_ovf   = '0;
    endtask

    // One clock of the reference behaviour, from the pre-edge model state.
    task automatic model_step(input logic [COL-1:0] wr, input logic [W-1:0] d,
                              input logic rdy);
        logic all_ne;
        logic do_pop;
        all_ne = 1'b1;
        for (int i = 0; i < COL; i++) if (q[i].size() == 0) all_ne = 1'b0;
        do_pop = all_ne && (!m_valid || rdy);
        if (do_pop) begin
            for (int i = 0; i < COL; i++) m_out[i*BWP +: BWP] = q[i].pop_front();
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < COL; i++) begin
            if (wr[i]) begin
                if (q[i].size() < DEPTH) q[i].push_back(d[i*BWP +: BWP]);
                else m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("out_valid", out_valid, m_valid);
        if (m_valid) chk("out_row", out, m_out);
        chk("o_ovf", o_ovf, m_ovf);
        chk("o_full", o_full, m_full());
        chk("o_empty", o_empty, m_empty());
    endtask

    task automatic step(input logic [COL-1:0] wr, input logic [W-1:0] d,
                        input logic rdy);
        @(negedge clk);
        fifo_wr   = wr;
        in_bus    = d;
        out_ready = rdy;
        if (out_valid && rdy) accepts++;
        model_step(wr, d, rdy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset   = 1'b0;
        fifo_wr = '0;
        model_clear();
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_out", out, '0);
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_full", o_full, 1'b0);
        chk("rst_ovf", o_ovf, '0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [W-1:0] row;
        logic [W-1:0] held;
        logic [W-1:0] rows [40];
        logic [BWP-1:0] v17;
        int n;

        // Test 1: reset in the middle of a stream with queued rows.
        #1;
        chk("init_valid", out_valid, 1'b0);
        chk("init_empty", o_empty, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) step('1, rnd_row(), 1'b0);
        do_reset();
        row = rnd_row();
        step('1, row, 1'b1);
        step('0, '0, 1'b1);
        chk("fresh_row", out, row);

        // Test 2: skewed single row.
        do_reset();
        row = '0;
        for (int i = 0; i < COL; i++) row[i*BWP +: BWP] = BWP'(100 + i);
        for (int t = 0; t < 20; t++) begin
            logic [COL-1:0] wr;
            wr = '0;
            for (int i = 0; i < COL; i++) if (t == 10 + i) wr[i] = 1'b1;
            step(wr, row, 1'b1);
            if (t == 17) chk("skew_not_yet", out_valid, 1'b0);
            if (t == 18) begin
                chk("skew_valid", out_valid, 1'b1);
                chk("skew_row", out, row);
            end
            if (t == 19) chk("skew_one_row", out_valid, 1'b0);
        end

        // Test 3: 40 skewed rows, pointer wrap.
        do_reset();
        for (int r = 0; r < 40; r++) rows[r] = rnd_row();
        n = 0;
        for (int t = 0; t < 50; t++) begin
            logic [COL-1:0] wr;
            logic [W-1:0]   d;
            wr = '0;
            d  = '0;
            for (int i = 0; i < COL; i++) begin
                if (t - i >= 0 && t - i < 40) begin
                    wr[i] = 1'b1;
                    d[i*BWP +: BWP] = rows[t-i][i*BWP +: BWP];
                end
            end
            step(wr, d, 1'b1);
            if (out_valid) n++;
        end
        chk("stream_rows", n, 40);
        chk("stream_ovf", o_ovf, '0);

        // Test 4: overflow of lane 0.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            row = '0;
            row[BWP-1:0] = BWP'(12'hA00 + k);
            step(8'h01, row, 1'b0);
        end
        chk("lane0_full", o_full, 1'b1);
        v17 = 22'h2AAAAA;
        row = '0;
        row[BWP-1:0] = v17;
        step(8'h01, row, 1'b0);
        chk("lane0_ovf", o_ovf, 8'h01);
        for (int k = 0; k < DEPTH; k++) step(8'hFE, rnd_row(), 1'b0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step('0, '0, 1'b1);
            if (out_valid && out[BWP-1:0] === v17) n++;
        end
        chk("dropped_value", n, 0);

        // Test 5: hold under backpressure, then pop+write on a full lane.
        do_reset();
        for (int k = 0; k < DEPTH + 1; k++) step('1, rnd_row(), 1'b0);
        held = out;
        for (int k = 0; k < 4; k++) begin
            step('0, rnd_row(), 1'b0);
            chk("hold_row", out, held);
        end
        chk("all_full", o_full, 1'b1);
        step(8'h01, rnd_row(), 1'b1);
        chk("popwr_full", o_full, 1'b1);
        chk("popwr_ovf", o_ovf, '0);
        for (int k = 0; k < 20; k++) step('0, '0, 1'b1);
        step(8'hFE, rnd_row(), 1'b1);
        for (int k = 0; k < 3; k++) step('0, '0, 1'b1);

        // Test 6: out_ready toggling with four rows queued.
        do_reset();
        for (int k = 0; k < 4; k++) step('1, rnd_row(), 1'b0);
        accepts = 0;
        for (int j = 0; j < 12; j++) step('0, '0, (j % 2) == 0);
        for (int j = 0; j < 3; j++) step('0, '0, 1'b0);
        chk("toggle_accepts", accepts, 4);

        // Random traffic.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic [31:0] v;
            v = $urandom();
            step(v[COL-1:0] | v[COL+7:COL], rnd_row(), $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
